fc_layer_mac_engine: RTL and testbench
======================================

Name: fc_layer_mac_engine

Overview:
- Initiator side of the packed weight ROM interface for a fully-connected layer; fc1 is the default instance.
- Consumes one input activation per handshake and drives the ROM address with that activation's feature index.
- Multiplies the activation by all NUM_NEURONS packed weights in parallel and accumulates them.
- After NUM_INPUTS beats, presents the raw accumulator vector downstream to the bias/activation stage.

Parameters:
- NUM_INPUTS, 784, input features per inference; ROM depth in packed rows.
- NUM_NEURONS, 16, output neurons; parallel MAC lanes.
- WEIGHT_WIDTH, 8, signed weight width.
- ACT_WIDTH, 8, signed activation width.
- ACC_WIDTH, 32, signed accumulator width per neuron.
- ADDR_WIDTH, $clog2(NUM_INPUTS), ROM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins an inference; sampled only in IDLE.
- busy  out  1  high in ACCUM and OUTPUT.
- in_valid  in  1  activation valid.
- in_ready  out  1  engine accepts an activation.
- in_data  in  ACT_WIDTH  signed activation.
- rom_addr  out  ADDR_WIDTH  feature index to the ROM.
- rom_data  in  NUM_NEURONS*WEIGHT_WIDTH  packed weights; lane i is bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH] and belongs to neuron i.
- out_valid  out  1  accumulator vector valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_NEURONS*ACC_WIDTH  neuron i is bits [i*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset values, held while rst_n is low:
  - state=IDLE, feature counter=0.
  - All accumulators=0, out_data=0.
  - out_valid=0, in_ready=0, busy=0, rom_addr=0.
- ROM timing:
  - The ROM is combinational.
  - rom_addr is driven directly from the feature counter register.
  - rom_data is used in the same cycle; there is no ROM wait state.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears all accumulators and the counter, then moves to ACCUM on the next edge.
- ACCUM:
  - in_ready=1.
  - On in_valid && in_ready, every lane i does acc[i] <= acc[i] + sext(in_data * w[i]).
  - The product is signed with full width WEIGHT_WIDTH+ACT_WIDTH, sign-extended to ACC_WIDTH.
  - The add wraps modulo 2^ACC_WIDTH; there is no saturation.
  - The counter increments on the same edge.
  - When the accepted beat has counter == NUM_INPUTS-1, move to OUTPUT and reset the counter to 0.
  - in_valid=0 stalls with no state change, for any number of cycles.
- OUTPUT:
  - out_valid=1 and in_ready=0; out_data reflects the accumulators and stays stable while out_ready=0.
  - out_valid rises the cycle after the last accepted beat.
  - On out_valid && out_ready, return to IDLE; out_valid drops on the next edge.
  - Accumulators keep their values until the next start.
- Throughput: one activation per cycle in ACCUM. Minimum inference time is 1 (start) + NUM_INPUTS + 1 (output handshake) cycles.
- Boundary conditions:
  - start while busy is ignored.
  - start asserted in the same cycle as the OUTPUT handshake is ignored; it must be re-asserted in IDLE.
  - in_valid outside ACCUM is ignored; no beat is consumed.
  - Asynchronous reset mid-ACCUM or mid-OUTPUT aborts immediately: partial sums are discarded, all outputs go to reset values, no out_valid is produced.
  - NUM_INPUTS=1 is legal: one beat, then OUTPUT.
  - The counter never exceeds NUM_INPUTS-1, so rom_addr always stays in range.

Decomposition:
- Package fc_pkg holds:
  - the state enum (IDLE, ACCUM, OUTPUT);
  - the default width constants (weight, activation, accumulator, product);
  - a signed product-extend function.
- One sub-module, fc_mac_lane: a single-neuron signed multiply-accumulate with clear and enable, generated NUM_NEURONS times.
- The top level holds the FSM, the counter, handshakes and packing.

Test Plan:
- Reset then idle: rst_n low 5 cycles, start=0 -> all outputs 0, busy=0, rom_addr=0 throughout.
- Small config (NUM_INPUTS=4, NUM_NEURONS=2) with model ROM lane0 weights {1,2,3,4}, lane1 weights {-1,-1,-1,-1}, activations {10,20,30,40} back-to-back -> out_data lane0=300, lane1=-100; out_valid the cycle after the 4th beat; rom_addr sequence 0,1,2,3.
- Signed extremes: weights all -128, activations all -128, NUM_INPUTS=4 -> each lane=65536. Then ACC_WIDTH=16 with the same stimulus -> each lane wraps to 0.
- Stalls and backpressure: random in_valid gaps, out_ready held low 10 cycles -> same sums as the gap-free run; out_data stable and out_valid high for all 10 cycles.
- Mid-run abort: reset pulsed after 2 of 4 beats, then a fresh start with activations {1,1,1,1} and the ROM from the second scenario -> lane0=10, lane1=-4 (no residue); start pulses during ACCUM are ignored.
- Default fc1 config: 784 random activations against the fc1 packed weight image -> out_data matches the reference model bit-exactly; latency is 786 cycles from start with no stalls.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types, default widths and arithmetic helper for the fully-connected MAC engine.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } fc_state_e;

  localparam int FC_WEIGHT_WIDTH = 8;
  localparam int FC_ACT_WIDTH    = 8;
  localparam int FC_ACC_WIDTH    = 32;
  localparam int FC_PROD_WIDTH   = FC_WEIGHT_WIDTH + FC_ACT_WIDTH;

  // Full signed product of two operands already sign-extended to 32 bits.
  // Callers truncate to their accumulator width, which equals sign-extending
  // the exact product and wrapping modulo 2^ACC_WIDTH.
  function automatic logic signed [63:0] product_extend(input logic signed [31:0] a,
                                                        input logic signed [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron's signed multiply-accumulate: clear has priority over enable.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
  parameter int ACT_WIDTH    = FC_ACT_WIDTH,
  parameter int ACC_WIDTH    = FC_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_i,
  input  logic                           en_i,
  input  logic signed [ACT_WIDTH-1:0]    act_i,
  input  logic signed [WEIGHT_WIDTH-1:0] weight_i,
  output logic        [ACC_WIDTH-1:0]    acc_o
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

  // Next accumulator value: zero on clear, wrapped sum on an accepted beat.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(product_extend(32'(act_i), 32'(weight_i)));
    end
  end

  // Accumulator register, discarded immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_mac_engine.sv
// Fully-connected layer MAC engine: walks the packed weight ROM one feature per
// accepted activation and presents the raw per-neuron sums downstream.
module fc_layer_mac_engine
  import fc_pkg::*;
#(
  parameter int NUM_INPUTS   = 784,
  parameter int NUM_NEURONS  = 16,
  parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
  parameter int ACT_WIDTH    = FC_ACT_WIDTH,
  parameter int ACC_WIDTH    = FC_ACC_WIDTH,
  parameter int ADDR_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [ACT_WIDTH-1:0]         in_data,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_NEURONS*ACC_WIDTH-1:0]    out_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

  fc_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic                  accept;
  logic                  clear;

  assign accept = in_ready_q && in_valid;
  assign clear  = (state_q == IDLE) && start;

  // Sequencer: state, feature counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) begin
              state_q     <= OUTPUT;
              cnt_q       <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // One MAC lane per neuron, each fed its own slice of the packed ROM row.
  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
    fc_mac_lane #(
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .ACT_WIDTH   (ACT_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .en_i    (accept),
      .act_i   (in_data),
      .weight_i(rom_data[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .acc_o   (out_data[g*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rom_addr  = cnt_q;

endmodule

// File: tb/tb_fc_layer_mac_engine.sv
// Bench for fc_layer_mac_engine: two small 4x2 engines (32- and 16-bit sums) share
// one stimulus channel, the default fc1 engine has its own; a behavioural model of
// every engine is compared against the outputs on each falling edge.
module tb_fc_layer_mac_engine;

  typedef enum int {M_IDLE, M_ACCUM, M_OUT} mPhase_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  logic              startS = 1'b0, inValidS = 1'b0, outReadyS = 1'b0;
  logic signed [7:0] inDataS = '0;
  logic              busyS, inReadyS, outValidS;
  logic [1:0]        romAddrS;
  logic [15:0]       romDataS;
  logic [63:0]       outDataS;

  logic              busyW, inReadyW, outValidW;
  logic [1:0]        romAddrW;
  logic [15:0]       romDataW;
  logic [31:0]       outDataW;

  logic              startF = 1'b0, inValidF = 1'b0, outReadyF = 1'b0;
  logic signed [7:0] inDataF = '0;
  logic              busyF, inReadyF, outValidF;
  logic [9:0]        romAddrF;
  logic [127:0]      romDataF;
  logic [511:0]      outDataF;

  logic signed [7:0] romS [4][2];
  logic signed [7:0] romF [784][16];
  logic signed [7:0] smallActs [4];

  mPhase_t mPhase [3];
  int      mCnt   [3];
  longint  mSum   [3][16];

  int assertCount = 0;
  int failCount   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  fc_layer_mac_engine #(.NUM_INPUTS(4), .NUM_NEURONS(2)) dutS (
    .clk(clk), .rst_n(rstN), .start(startS), .busy(busyS),
    .in_valid(inValidS), .in_ready(inReadyS), .in_data(inDataS),
    .rom_addr(romAddrS), .rom_data(romDataS),
    .out_valid(outValidS), .out_ready(outReadyS), .out_data(outDataS)
  );

  fc_layer_mac_engine #(.NUM_INPUTS(4), .NUM_NEURONS(2), .ACC_WIDTH(16)) dutW (
    .clk(clk), .rst_n(rstN), .start(startS), .busy(busyW),
    .in_valid(inValidS), .in_ready(inReadyW), .in_data(inDataS),
    .rom_addr(romAddrW), .rom_data(romDataW),
    .out_valid(outValidW), .out_ready(outReadyS), .out_data(outDataW)
  );

  fc_layer_mac_engine dutF (
    .clk(clk), .rst_n(rstN), .start(startF), .busy(busyF),
    .in_valid(inValidF), .in_ready(inReadyF), .in_data(inDataF),
    .rom_addr(romAddrF), .rom_data(romDataF),
    .out_valid(outValidF), .out_ready(outReadyF), .out_data(outDataF)
  );

  // Combinational weight ROMs answering each engine's address.
  always_comb begin
    romDataS = '0;
    romDataW = '0;
    for (int i = 0; i < 2; i++) begin
      romDataS[i*8 +: 8] = romS[romAddrS][i];
      romDataW[i*8 +: 8] = romS[romAddrW][i];
    end
  end

  always_comb begin
    romDataF = '0;
    if (romAddrF < 10'd784) begin
      for (int i = 0; i < 16; i++) romDataF[i*8 +: 8] = romF[romAddrF][i];
    end
  end

  function automatic int nIn(input int k);
    return (k < 2) ? 4 : 784;
  endfunction

  function automatic int nNeu(input int k);
    return (k < 2) ? 2 : 16;
  endfunction

  function automatic logic stIn(input int k);
    return (k < 2) ? startS : startF;
  endfunction

  function automatic logic vIn(input int k);
    return (k < 2) ? inValidS : inValidF;
  endfunction

  function automatic logic rIn(input int k);
    return (k < 2) ? outReadyS : outReadyF;
  endfunction

  function automatic logic signed [7:0] dIn(input int k);
    return (k < 2) ? inDataS : inDataF;
  endfunction

  function automatic logic signed [7:0] wgt(input int k, input int f, input int i);
    return (k < 2) ? romS[f][i] : romF[f][i];
  endfunction

  // Reference model: sums are exact integers; phases follow the inference lifecycle.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < 3; k++) begin
        mPhase[k] <= M_IDLE;
        mCnt[k]   <= 0;
        for (int i = 0; i < 16; i++) mSum[k][i] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        case (mPhase[k])
          M_IDLE: if (stIn(k)) begin
            mPhase[k] <= M_ACCUM;
            mCnt[k]   <= 0;
            for (int i = 0; i < 16; i++) mSum[k][i] <= 0;
          end
          M_ACCUM: if (vIn(k)) begin
            for (int i = 0; i < nNeu(k); i++)
              mSum[k][i] <= mSum[k][i] + longint'(dIn(k)) * longint'(wgt(k, mCnt[k], i));
            if (mCnt[k] == nIn(k) - 1) begin
              mCnt[k]   <= 0;
              mPhase[k] <= M_OUT;
            end else begin
              mCnt[k] <= mCnt[k] + 1;
            end
          end
          default: if (rIn(k)) mPhase[k] <= M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [63:0] actLane(input int k, input int i);
    logic [63:0] v;
    v = '0;
    case (k)
      0:       v[31:0] = outDataS[i*32 +: 32];
      1:       v[15:0] = outDataW[i*16 +: 16];
      default: v[31:0] = outDataF[i*32 +: 32];
    endcase
    return v;
  endfunction

  function automatic logic [63:0] expLane(input int k, input int i);
    logic [63:0] s;
    logic [63:0] v;
    s = mSum[k][i];
    v = '0;
    if (k == 1) v[15:0] = s[15:0];
    else        v[31:0] = s[31:0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInst(input int k, input string tag, input logic b, input logic ir,
                           input logic ov, input logic [9:0] ra);
    checkOutput({tag, " busy"},      64'(b),  64'(mPhase[k] != M_IDLE));
    checkOutput({tag, " in_ready"},  64'(ir), 64'(mPhase[k] == M_ACCUM));
    checkOutput({tag, " out_valid"}, 64'(ov), 64'(mPhase[k] == M_OUT));
    checkOutput({tag, " rom_addr"},  64'(ra), 64'(mCnt[k]));
    for (int i = 0; i < nNeu(k); i++)
      checkOutput($sformatf("%s lane%0d", tag, i), actLane(k, i), expLane(k, i));
  endtask

  // Per-cycle comparison of all three engines against the model.
  always @(negedge clk) begin
    checkInst(0, "s32", busyS, inReadyS, outValidS, {8'b0, romAddrS});
    checkInst(1, "s16", busyW, inReadyW, outValidW, {8'b0, romAddrW});
    checkInst(2, "fc1", busyF, inReadyF, outValidF, romAddrF);
  end

  // Literal expectations for the small engines after an inference.
  task automatic checkSmall(input string name, input int e0, input int e1);
    checkOutput({name, " s32 lane0"}, actLane(0, 0), {32'b0, 32'(e0)});
    checkOutput({name, " s32 lane1"}, actLane(0, 1), {32'b0, 32'(e1)});
    checkOutput({name, " s16 lane0"}, actLane(1, 0), {48'b0, 16'(e0)});
    checkOutput({name, " s16 lane1"}, actLane(1, 1), {48'b0, 16'(e1)});
  endtask

  // One inference on the small channel with optional gaps, output hold and start noise.
  task automatic applyStimulus(input int gapMode, input int holdCycles, input bit startNoise);
    int beat;
    int guard;
    bit acc;
    @(negedge clk);
    startS = 1'b1; inValidS = 1'b1; inDataS = 8'sd77; outReadyS = 1'b0;
    @(negedge clk);
    startS = 1'b0;
    beat = 0;
    guard = 0;
    while (beat < 4 && guard < 100) begin
      if (gapMode != 0 && $urandom_range(0, 2) == 0) begin
        inValidS = 1'b0;
      end else begin
        inValidS = 1'b1;
        inDataS  = smallActs[beat];
      end
      startS = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = inValidS && (mPhase[0] == M_ACCUM);
      @(negedge clk);
      if (acc) beat++;
      guard++;
    end
    checkOutput("beat budget expired", 64'(guard >= 100), 64'(0));
    startS = 1'b0; inValidS = 1'b1; inDataS = 8'sd99;
    repeat (holdCycles) @(negedge clk);
    outReadyS = 1'b1; startS = 1'b1;
    @(negedge clk);
    outReadyS = 1'b0; startS = 1'b0; inValidS = 1'b0;
    @(negedge clk);
  endtask

  // Full fc1 inference with no stalls, measuring cycles from start to handshake.
  task automatic runFull();
    int cycles;
    bit done;
    @(negedge clk);
    startF = 1'b1; outReadyF = 1'b1; inValidF = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      startF = 1'b0;
      cycles++;
      done = (!busyF && cycles > 1);
      if (!done) begin
        inValidF = 1'b1;
        inDataF  = 8'($urandom);
      end
    end while (!done && cycles < 3000);
    inValidF = 1'b0; outReadyF = 1'b0;
    checkOutput("fc1 latency", 64'(cycles), 64'(786));
  endtask

  initial begin
    for (int f = 0; f < 784; f++)
      for (int i = 0; i < 16; i++) romF[f][i] = 8'($urandom);

    rstN = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset s32 busy", 64'(busyS), 64'(0));
    checkOutput("reset s32 in_ready", 64'(inReadyS), 64'(0));
    checkOutput("reset s32 out_valid", 64'(outValidS), 64'(0));
    checkOutput("reset fc1 rom_addr", 64'(romAddrF), 64'(0));
    checkOutput("reset fc1 out_data", 64'(|outDataF), 64'(0));
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic 4x2 inference");
    for (int f = 0; f < 4; f++) begin
      romS[f][0] = 8'(f + 1);
      romS[f][1] = -8'sd1;
    end
    smallActs[0] = 8'sd10; smallActs[1] = 8'sd20; smallActs[2] = 8'sd30; smallActs[3] = 8'sd40;
    applyStimulus(0, 0, 1'b0);
    checkSmall("basic", 300, -100);

    $display("[TB] signed extremes");
    for (int f = 0; f < 4; f++) begin
      romS[f][0] = 8'sh80;
      romS[f][1] = 8'sh80;
      smallActs[f] = 8'sh80;
    end
    applyStimulus(0, 0, 1'b0);
    checkSmall("extreme", 65536, 65536);

    $display("[TB] stalls and backpressure");
    for (int f = 0; f < 4; f++) begin
      romS[f][0] = 8'(f + 1);
      romS[f][1] = -8'sd1;
    end
    smallActs[0] = 8'sd10; smallActs[1] = 8'sd20; smallActs[2] = 8'sd30; smallActs[3] = 8'sd40;
    applyStimulus(1, 10, 1'b0);
    checkSmall("stall", 300, -100);

    $display("[TB] mid-run abort");
    @(negedge clk);
    startS = 1'b1;
    @(negedge clk);
    startS = 1'b0; inValidS = 1'b1; inDataS = 8'sd50;
    repeat (2) @(negedge clk);
    inValidS = 1'b0;
    #2 rstN = 1'b0;
    @(negedge clk);
    checkOutput("abort s32 busy", 64'(busyS), 64'(0));
    checkOutput("abort s32 lane0", actLane(0, 0), 64'(0));
    @(negedge clk);
    rstN = 1'b1;
    for (int f = 0; f < 4; f++) smallActs[f] = 8'sd1;
    applyStimulus(1, 2, 1'b1);
    checkSmall("abort", 10, -4);

    $display("[TB] default fc1 inference");
    runFull();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
